vga_sync_gen: RTL and testbench

//   640x480@60Hz VGA timing generator for the Nexys3 display path.

---
 rtl/vga_sync_gen.sv | 99 +++++++++
 tb/tb_vga_sync_gen.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: stage-0 pixel counters plus a pixel-aligned stage-1
// register layer for hsync, vsync and blanked colour. Advances only on pix_en.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       pix_en,
  input  logic [7:0] rgb_in,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_LO  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_HI  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_LO  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_HI  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [7:0] rgb_q, rgb_d;
  logic       frame_start_q, frame_start_d;

  logic h_end, v_end, in_hsync, in_vsync;

  assign h_end    = (hc_q == H_LAST);
  assign v_end    = (vc_q == V_LAST);
  assign in_hsync = (hc_q >= H_SYNC_LO) && (hc_q <= H_SYNC_HI);
  assign in_vsync = (vc_q >= V_SYNC_LO) && (vc_q <= V_SYNC_HI);
  assign video_on = (hc_q < H_VIS) && (vc_q < V_VIS);

  always_comb begin
    hc_d          = hc_q;
    vc_d          = vc_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      hc_d = h_end ? 10'd0 : hc_q + 10'd1;
      if (h_end) begin
        vc_d = v_end ? 10'd0 : vc_q + 10'd1;
      end
      // Stage 1 samples the pre-edge counters so it trails hc/vc by one pixel.
      hsync_d       = in_hsync ? SYNC_POL : ~SYNC_POL;
      vsync_d       = in_vsync ? SYNC_POL : ~SYNC_POL;
      rgb_d         = video_on ? rgb_in : 8'h00;
      frame_start_d = h_end && v_end;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      rgb_q         <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size 640x480 instance for line-level timing and reset,
// plus a shrunken instance so whole-frame behaviour fits in a short run.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       clr, pix_en;
  logic [7:0] rgb_in;
  logic [9:0] hc, vc;
  logic       video_on, hsync, vsync, frame_start;
  logic [7:0] rgb;

  logic       s_clr, s_pix_en;
  logic [7:0] s_rgb_in;
  logic [9:0] s_hc, s_vc;
  logic       s_video_on, s_hsync, s_vsync, s_frame_start;
  logic [7:0] s_rgb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk(clk), .clr(clr), .pix_en(pix_en), .rgb_in(rgb_in),
    .hc(hc), .vc(vc), .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .frame_start(frame_start)
  );

  // Small frame: H 8+2+3+3 = 16, V 4+1+2+2 = 9, so one frame = 144 pixels.
  vga_sync_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) dut_small (
    .clk(clk), .clr(s_clr), .pix_en(s_pix_en), .rgb_in(s_rgb_in),
    .hc(s_hc), .vc(s_vc), .video_on(s_video_on), .hsync(s_hsync), .vsync(s_vsync),
    .rgb(s_rgb), .frame_start(s_frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_low, vs_low, n_fs, t_fs1, t_fs2, p;
    logic [9:0] prev_hc, prev_vc;

    clr = 1'b1; pix_en = 1'b1; rgb_in = 8'hFF;
    s_clr = 1'b1; s_pix_en = 1'b0; s_rgb_in = 8'h00;

    // Reset with strobe and colour active: clr wins.
    for (int i = 0; i < 3; i++) tick();
    check("rst_hc", hc, 0);
    check("rst_vc", vc, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_rgb", rgb, 8'h00);
    check("rst_frame_start", frame_start, 0);

    // 801 strobes at 1-in-4 across line 0 into line 1.
    clr = 1'b0; pix_en = 1'b0; rgb_in = 8'hA5;
    hs_low = 0;
    for (int s = 1; s <= 801; s++) begin
      pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      p = s % 800;
      check("hc_step", hc, p);
      check("vc_step", vc, (s >= 800) ? 1 : 0);
      check("video_on", video_on, (p < 640) ? 1 : 0);
      check("hsync_line", hsync, (p >= 657 && p <= 752) ? 0 : 1);
      check("vsync_line", vsync, 1);
      check("rgb_line", rgb, (p >= 1 && p <= 640) ? 8'hA5 : 8'h00);
      check("frame_start_line", frame_start, 0);
      if (hsync == 1'b0) hs_low++;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("hc_hold", hc, p);
      end
    end
    check("hsync_width", hs_low, 96);

    // Run to hc=300 on line 1, then reset mid-line while the strobe is idle.
    pix_en = 1'b1;
    for (int i = 0; i < 299; i++) tick();
    pix_en = 1'b0;
    tick();
    check("pre_rst_hc", hc, 300);
    check("pre_rst_vc", vc, 1);
    check("pre_rst_rgb", rgb, 8'hA5);
    clr = 1'b1;
    tick();
    check("mid_rst_hc", hc, 0);
    check("mid_rst_vc", vc, 0);
    check("mid_rst_rgb", rgb, 8'h00);
    check("mid_rst_hsync", hsync, 1);
    check("mid_rst_vsync", vsync, 1);
    check("mid_rst_frame_start", frame_start, 0);
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_hc", hc, 0);
      check("idle_vc", vc, 0);
      check("idle_frame_start", frame_start, 0);
    end

    // Small instance: pix_en tied high for two frames plus a few pixels.
    s_clr = 1'b1; s_pix_en = 1'b1; s_rgb_in = 8'h3C;
    tick();
    s_clr = 1'b0;
    prev_hc = 10'd0; prev_vc = 10'd0;
    vs_low = 0; n_fs = 0; t_fs1 = 0; t_fs2 = 0;
    for (int cyc = 1; cyc <= 290; cyc++) begin
      tick();
      check("s_rgb", s_rgb, (prev_vc < 4 && prev_hc < 8) ? 8'h3C : 8'h00);
      check("s_hsync", s_hsync, (prev_hc >= 10 && prev_hc <= 12) ? 0 : 1);
      check("s_vsync", s_vsync, (prev_vc >= 5 && prev_vc <= 6) ? 0 : 1);
      if (s_vsync == 1'b0) vs_low++;
      if (s_frame_start == 1'b1) begin
        n_fs++;
        if (n_fs == 1) t_fs1 = cyc;
        else if (n_fs == 2) t_fs2 = cyc;
      end
      prev_hc = s_hc;
      prev_vc = s_vc;
    end
    check("s_frame_start_count", n_fs, 2);
    check("s_frame_start_first", t_fs1, 144);
    check("s_frame_start_gap", t_fs2 - t_fs1, 144);
    check("s_vsync_low_clk", vs_low, 64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
